// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer and the ALU decode logic.
//   seq_state_t : sequencer FSM state encoding
//   OP_BLT/OP_BEQ : conditional-branch ALU opcodes whose Brc_J result
//                   decides whether a branch is taken
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } seq_state_t;

    localparam logic [3:0] OP_BLT = 4'b0110;
    localparam logic [3:0] OP_BEQ = 4'b0111;

    // True for the opcodes whose branch condition comes from Brc_J.
    function automatic logic is_cond_branch(input logic [3:0] aluop);
        return (aluop == OP_BLT) || (aluop == OP_BEQ);
    endfunction

endpackage

// File: rtl/prog_seq_ctrl_if.sv
// Instruction-memory fetch handshake.
//   Imem_req : sequencer -> memory, request held until Imem_rdy
//   Imem_rdy : memory -> sequencer, Imem_dat valid this cycle
//   Imem_dat : memory -> sequencer, fetched instruction word
// master = sequencer side, slave = instruction memory side.
interface prog_seq_ctrl_if #(
    parameter int INSTR_W = 9
);
    logic               Imem_req;
    logic               Imem_rdy;
    logic [INSTR_W-1:0] Imem_dat;

    modport master (output Imem_req, input Imem_rdy, input Imem_dat);
    modport slave  (input Imem_req, output Imem_rdy, output Imem_dat);
endinterface

// File: rtl/next_pc_sel.sv
// Next program-counter selection for the EXEC cycle.
//   pc      : current program counter
//   target  : absolute jump/branch target
//   jen     : unconditional jump enable from the ALU
//   brc_j   : branch condition result, 0 means condition true
//   aluop   : decoded opcode, selects whether brc_j is consulted
//   next_pc : target when taken, otherwise pc+1 (wraps modulo 2**PC_W)
module next_pc_sel
    import seq_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    input  logic            jen,
    input  logic            brc_j,
    input  logic [3:0]      aluop,
    output logic [PC_W-1:0] next_pc
);

    logic taken;

    always_comb begin
        // Brc_J is active-low: a conditional branch is taken when it is 0.
        taken   = jen | (is_cond_branch(aluop) & ~brc_j);
        // Width-matched add drops the carry, so all-ones rolls over to 0.
        next_pc = taken ? target : (pc + PC_W'(1));
    end

endmodule

// File: rtl/prog_seq_ctrl.sv
// Fetch/execute sequencer that owns the program counter.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   Start        : level input; a rising edge in IDLE/HALT launches at START_PC
//   imem         : instruction-memory fetch handshake (master side)
//   Aluop, Halt_op, Wr_en_dec : decode of the latched instruction
//   Jen, Brc_J, Target        : ALU jump/branch results and jump target
//   Pc, Instr    : current program counter and latched instruction
//   Reg_wen      : register-file write strobe, only in EXEC
//   Busy, Done   : high in FETCH/EXEC, high in HALT
module prog_seq_ctrl
    import seq_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = 9,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    prog_seq_ctrl_if.master    imem,
    input  logic [3:0]         Aluop,
    input  logic               Halt_op,
    input  logic               Wr_en_dec,
    input  logic               Jen,
    input  logic               Brc_J,
    input  logic [PC_W-1:0]    Target,
    output logic [PC_W-1:0]    Pc,
    output logic [INSTR_W-1:0] Instr,
    output logic               Reg_wen,
    output logic               Busy,
    output logic               Done
);

    seq_state_t         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               start_q, start_d;
    logic               start_edge;
    logic [PC_W-1:0]    exec_next_pc;

    next_pc_sel #(
        .PC_W (PC_W)
    ) u_next_pc_sel (
        .pc      (pc_q),
        .target  (Target),
        .jen     (Jen),
        .brc_j   (Brc_J),
        .aluop   (Aluop),
        .next_pc (exec_next_pc)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        start_d    = Start;
        start_edge = Start & ~start_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                // Start held high across HALT gives no edge, so no relaunch.
                if (start_edge) begin
                    pc_d    = START_PC;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem.Imem_rdy) begin
                    instr_d = imem.Imem_dat;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (Halt_op) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = exec_next_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            instr_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            start_q <= start_d;
        end
    end

    // Strobes decode straight from the state flop, so an asynchronous reset
    // drops Imem_req and Reg_wen in the same cycle it is asserted.
    assign imem.Imem_req = (state_q == S_FETCH);
    assign Reg_wen       = (state_q == S_EXEC) && !Halt_op && Wr_en_dec;
    assign Busy          = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign Done          = (state_q == S_HALT);
    assign Pc            = pc_q;
    assign Instr         = instr_q;

endmodule
